// File: rtl/pmem_arbiter_pkg.sv
// pmem_arbiter_pkg: shared state/side encodings and default widths for the line-memory arbiter.
package pmem_arb_types;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic {SIDE_I, SIDE_D} arb_side_t;

    localparam int LINE_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter putting the I-cache and D-cache line ports onto one
// single-ported memory, one registered transfer in flight at a time.
module pmem_arbiter
    import pmem_arb_types::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read_i,
    input  logic              pmem_write_i,
    input  logic [ADDR_W-1:0] pmem_address_i,
    input  logic [LINE_W-1:0] pmem_wdata_i,
    output logic [LINE_W-1:0] pmem_rdata_i,
    output logic              pmem_resp_i,
    input  logic              pmem_read_d,
    input  logic              pmem_write_d,
    input  logic [ADDR_W-1:0] pmem_address_d,
    input  logic [LINE_W-1:0] pmem_wdata_d,
    output logic [LINE_W-1:0] pmem_rdata_d,
    output logic              pmem_resp_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state, state_nx;
    arb_side_t         last_grant, last_grant_nx;
    logic              mem_read_nx, mem_write_nx;
    logic [ADDR_W-1:0] mem_address_nx;
    logic [LINE_W-1:0] mem_wdata_nx;
    logic              pend_i, pend_d, pick_d;

    assign pend_i = pmem_read_i | pmem_write_i;
    assign pend_d = pmem_read_d | pmem_write_d;
    // D wins when alone or when I had the previous grant
    assign pick_d = pend_d & (~pend_i | (last_grant == SIDE_I));

    assign pmem_rdata_i = mem_rdata;
    assign pmem_rdata_d = mem_rdata;

    always_comb begin
        state_nx       = state;
        last_grant_nx  = last_grant;
        mem_read_nx    = mem_read;
        mem_write_nx   = mem_write;
        mem_address_nx = mem_address;
        mem_wdata_nx   = mem_wdata;
        pmem_resp_i    = 1'b0;
        pmem_resp_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nx       = SERVE_D;
                    last_grant_nx  = SIDE_D;
                    mem_write_nx   = pmem_write_d;
                    mem_read_nx    = pmem_read_d & ~pmem_write_d;
                    mem_address_nx = pmem_address_d;
                    mem_wdata_nx   = pmem_wdata_d;
                end else if (pend_i) begin
                    state_nx       = SERVE_I;
                    last_grant_nx  = SIDE_I;
                    mem_write_nx   = pmem_write_i;
                    mem_read_nx    = pmem_read_i & ~pmem_write_i;
                    mem_address_nx = pmem_address_i;
                    mem_wdata_nx   = pmem_wdata_i;
                end
            end
            SERVE_I, SERVE_D: begin
                pmem_resp_i = (state == SERVE_I) & mem_resp;
                pmem_resp_d = (state == SERVE_D) & mem_resp;
                if (mem_resp) begin
                    state_nx     = IDLE;
                    mem_read_nx  = 1'b0;
                    mem_write_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= SIDE_I;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_nx;
            last_grant  <= last_grant_nx;
            mem_read    <= mem_read_nx;
            mem_write   <= mem_write_nx;
            mem_address <= mem_address_nx;
            mem_wdata   <= mem_wdata_nx;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: vector table of request patterns plus hand sequences for reset, conflict
// streaming and early-response cases; expected transfers are queued on drive and popped per strobe.
module tb_pmem_arbiter;
    import pmem_arb_types::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0, rst = 1'b1;
    logic          rd_i = 1'b0, wr_i = 1'b0, rd_d = 1'b0, wr_d = 1'b0;
    logic [AW-1:0] addr_i = '0, addr_d = '0;
    logic [LW-1:0] wd_i = '0, wd_d = '0, rdata_i, rdata_d;
    logic          resp_i, resp_d;
    logic          mem_read, mem_write, mem_resp = 1'b0;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata, mem_rdata = '0;

    pmem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .pmem_read_i(rd_i), .pmem_write_i(wr_i), .pmem_address_i(addr_i), .pmem_wdata_i(wd_i),
        .pmem_rdata_i(rdata_i), .pmem_resp_i(resp_i),
        .pmem_read_d(rd_d), .pmem_write_d(wr_d), .pmem_address_d(addr_d), .pmem_wdata_d(wd_d),
        .pmem_rdata_d(rdata_d), .pmem_resp_d(resp_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        arb_side_t     side;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    typedef struct {
        bit            rst_first;
        logic          rd_i, wr_i;
        logic [AW-1:0] addr_i;
        logic [LW-1:0] wd_i;
        logic          rd_d, wr_d;
        logic [AW-1:0] addr_d;
        logic [LW-1:0] wd_d;
        int            lat;
    } vec_t;

    exp_t          sb[$];
    logic [LW-1:0] mem_model [bit [AW-1:0]];
    vec_t          vt[6];
    arb_side_t     tb_last = SIDE_I;
    int            passes = 0, total = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] line_at(input bit [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic push(input arb_side_t s);
        exp_t e;
        e.side  = s;
        e.wr    = (s == SIDE_I) ? wr_i : wr_d;
        e.addr  = (s == SIDE_I) ? addr_i : addr_d;
        e.wdata = (s == SIDE_I) ? wd_i : wd_d;
        sb.push_back(e);
    endtask

    // queue the transfers the current request pattern should produce, in grant order
    task automatic issue(output int cnt);
        logic pi, pd;
        pi = rd_i | wr_i;
        pd = rd_d | wr_d;
        cnt = 0;
        if (pi && pd) begin
            if (tb_last == SIDE_I) begin push(SIDE_D); push(SIDE_I); tb_last = SIDE_I; end
            else begin push(SIDE_I); push(SIDE_D); tb_last = SIDE_D; end
            cnt = 2;
        end else if (pd) begin
            push(SIDE_D); tb_last = SIDE_D; cnt = 1;
        end else if (pi) begin
            push(SIDE_I); tb_last = SIDE_I; cnt = 1;
        end
    endtask

    task automatic serve(input int lat, input bit keep);
        exp_t          e;
        int            n;
        logic [LW-1:0] exp_rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_read | mem_write) && n < 20);
        chk("grant_latency", n, 1);
        if (n >= 20 || sb.size() == 0) return;
        e = sb.pop_front();
        chk("mem_address", mem_address, e.addr);
        chk("mem_write", mem_write, e.wr);
        chk("mem_read", mem_read, !e.wr);
        if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
        repeat (lat) begin
            @(negedge clk);
            chk("strobe_hold", {resp_i, resp_d, mem_read, mem_write, mem_address}, {2'b00, !e.wr, e.wr, e.addr});
        end
        if (e.wr) mem_model[mem_address] = mem_wdata;
        exp_rd = e.wr ? {8{32'hDEAD_BEEF}} : line_at(e.addr);
        mem_rdata = exp_rd;
        mem_resp = 1'b1;
        #1;
        chk("resp_i", resp_i, e.side == SIDE_I);
        chk("resp_d", resp_d, e.side == SIDE_D);
        chk("rdata_i", rdata_i, exp_rd);
        chk("rdata_d", rdata_d, exp_rd);
        @(negedge clk);
        mem_resp = 1'b0;
        if (!keep && e.side == SIDE_I) begin rd_i = 1'b0; wr_i = 1'b0; end
        if (!keep && e.side == SIDE_D) begin rd_d = 1'b0; wr_d = 1'b0; end
        chk("strobe_drop", {mem_read, mem_write, resp_i, resp_d}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_last = SIDE_I;
    endtask

    initial begin
        int cnt;
        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h60, LW'(0), 1'b0, 1'b0, 32'h0, LW'(0), 2};
        vt[1] = '{1'b0, 1'b0, 1'b0, 32'h0, LW'(0), 1'b0, 1'b1, 32'h1000, {32{8'h5A}}, 1};
        vt[2] = '{1'b0, 1'b0, 1'b0, 32'h0, LW'(0), 1'b1, 1'b0, 32'h1000, LW'(0), 0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h20, LW'(0), 1'b1, 1'b0, 32'h40, LW'(0), 1};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h80, {8{32'h8080_0001}}, 1'b0, 1'b0, 32'h0, LW'(0), 0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 32'h300, {8{32'h0300_0003}}, 1'b1, 1'b0, 32'h400, LW'(0), 1};
        mem_model[32'h60] = {32{8'hAB}};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_flags", {mem_read, mem_write, resp_i, resp_d}, 0);
        chk("reset_address", mem_address, 0);
        chk("reset_wdata", mem_wdata, 0);
        for (int k = 0; k < 6; k++) begin
            if (vt[k].rst_first) do_reset();
            @(negedge clk);
            rd_i = vt[k].rd_i; wr_i = vt[k].wr_i; addr_i = vt[k].addr_i; wd_i = vt[k].wd_i;
            rd_d = vt[k].rd_d; wr_d = vt[k].wr_d; addr_d = vt[k].addr_d; wd_d = vt[k].wd_d;
            issue(cnt);
            for (int j = 0; j < cnt; j++) serve(vt[k].lat, 1'b0);
        end
        chk("mem_holds_line", line_at(32'h1000), {32{8'h5A}});

        // continuous conflict: both sides keep requesting, grants must alternate D first
        do_reset();
        @(negedge clk);
        rd_i = 1'b1; addr_i = 32'h100; rd_d = 1'b1; addr_d = 32'h200;
        for (int j = 0; j < 6; j++) push((j % 2 == 0) ? SIDE_D : SIDE_I);
        for (int j = 0; j < 6; j++) serve(1, 1'b1);
        rd_i = 1'b0; rd_d = 1'b0;
        tb_last = SIDE_I;

        // reset while D write is in flight, then a stray response
        @(negedge clk);
        wr_d = 1'b1; addr_d = 32'h500; wd_d = {8{32'h1234_5678}};
        @(negedge clk);
        chk("pre_rst_strobe", {mem_read, mem_write}, 2'b01);
        rst = 1'b1; wr_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_flags", {mem_read, mem_write}, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        mem_resp = 1'b1;
        #1;
        chk("late_resp_dropped", {resp_i, resp_d}, 0);
        @(negedge clk);
        mem_resp = 1'b0;
        chk("late_resp_no_strobe", {mem_read, mem_write}, 0);
        tb_last = SIDE_I;

        // last_grant restored by reset: D first; immediate response must not reissue
        rd_i = 1'b1; addr_i = 32'h700; rd_d = 1'b1; addr_d = 32'h740;
        issue(cnt);
        for (int j = 0; j < cnt; j++) serve(0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("no_duplicate", {mem_read, mem_write, resp_i, resp_d}, 0);
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
